front_panel_entry: RTL and testbench

Front-panel command sequencer directly downstream of the keypad scanner. Consumes its single-cycle key pulses, assembles hex digits into a 16-bit entry buffer, and turns command keys (load, store/increment, decrement, register transfers) into memory and CPU-register write transactions over simple req/ack handshakes. Holds the current panel address and the last byte read for the display driver.

---
 rtl/front_panel_entry.sv | 212 +++++++++++++++++++++
 tb/tb_front_panel_entry.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_entry.sv
// Front-panel command sequencer: collects keypad hex digits into an entry
// buffer and turns command keys into memory / CPU-register write transactions.
module front_panel_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_hex,
  input  logic        key_load,
  input  logic        key_storeinc,
  input  logic        key_dec,
  input  logic        key_toA,
  input  logic        key_toX,
  input  logic        key_toY,
  input  logic        key_toSP,
  input  logic        key_toPC,
  input  logic        halted,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_req,
  output logic [2:0]  reg_sel,
  output logic [15:0] reg_data,
  input  logic        reg_ack,
  output logic [15:0] disp_addr,
  output logic [7:0]  disp_data,
  output logic [15:0] entry,
  output logic [2:0]  ndigits,
  output logic        busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 3;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_REG} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            reg_req_q, reg_req_d;
  logic [SW-1:0]   reg_sel_q, reg_sel_d;
  logic [AW-1:0]   reg_data_q, reg_data_d;
  logic [AW-1:0]   disp_addr_q, disp_addr_d;
  logic [DW-1:0]   disp_data_q, disp_data_d;
  logic [AW-1:0]   entry_q, entry_d;
  logic [NW-1:0]   ndigits_q, ndigits_d;
  logic            busy_q, busy_d;

  logic            cmd_any_c;
  logic [3:0]      hex_digit_c;
  logic [SW-1:0]   reg_sel_c;

  assign cmd_any_c = key_load | key_storeinc | key_dec | key_toPC |
                     key_toA | key_toX | key_toY | key_toSP;

  // Lowest set hex key wins; higher simultaneous bits are dropped.
  always_comb begin
    hex_digit_c = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (key_hex[i]) hex_digit_c = 4'(i);
    end
  end

  // Register target select in transfer priority order PC > A > X > Y > SP.
  always_comb begin
    reg_sel_c = 3'd3;
    if (key_toPC)     reg_sel_c = 3'd4;
    else if (key_toA) reg_sel_c = 3'd0;
    else if (key_toX) reg_sel_c = 3'd1;
    else if (key_toY) reg_sel_c = 3'd2;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_req_d   = reg_req_q;
    reg_sel_d   = reg_sel_q;
    reg_data_d  = reg_data_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    entry_d     = entry_q;
    ndigits_d   = ndigits_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_any_c) begin
          // A command pulse always swallows hex pulses, even when ignored.
          if (halted) begin
            if (key_load) begin
              disp_addr_d = entry_q;
              mem_addr_d  = entry_q;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              entry_d     = '0;
              ndigits_d   = '0;
              state_d     = S_READ;
            end else if (key_storeinc) begin
              mem_addr_d  = disp_addr_q;
              mem_wdata_d = entry_q[DW-1:0];
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              state_d     = S_WRITE;
            end else if (key_dec) begin
              disp_addr_d = disp_addr_q - AW'(1);
              mem_addr_d  = disp_addr_q - AW'(1);
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              state_d     = S_READ;
            end else begin
              reg_req_d   = 1'b1;
              reg_sel_d   = reg_sel_c;
              reg_data_d  = key_toPC ? entry_q : {8'h00, entry_q[7:0]};
              state_d     = S_REG;
            end
          end
        end else if (|key_hex) begin
          entry_d = {entry_q[11:0], hex_digit_c};
          if (ndigits_q != NW'(4)) ndigits_d = ndigits_q + NW'(1);
        end
      end

      S_READ: begin
        if (mem_ack) begin
          disp_data_d = mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_WRITE: begin
        // Write completion chains straight into a display-refresh read.
        if (mem_ack) begin
          disp_addr_d = disp_addr_q + AW'(1);
          mem_addr_d  = disp_addr_q + AW'(1);
          mem_we_d    = 1'b0;
          entry_d     = '0;
          ndigits_d   = '0;
          state_d     = S_READ;
        end
      end

      S_REG: begin
        if (reg_ack) begin
          reg_req_d = 1'b0;
          entry_d   = '0;
          ndigits_d = '0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_req_q   <= 1'b0;
      reg_sel_q   <= '0;
      reg_data_q  <= '0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      entry_q     <= '0;
      ndigits_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_req_q   <= reg_req_d;
      reg_sel_q   <= reg_sel_d;
      reg_data_q  <= reg_data_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      entry_q     <= entry_d;
      ndigits_q   <= ndigits_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign reg_req   = reg_req_q;
  assign reg_sel   = reg_sel_q;
  assign reg_data  = reg_data_q;
  assign disp_addr = disp_addr_q;
  assign disp_data = disp_data_q;
  assign entry     = entry_q;
  assign ndigits   = ndigits_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_front_panel_entry.sv
// Scoreboard bench for front_panel_entry: a key-level model predicts panel
// state and the transactions each key should cause; a responder checks them.
module tb_front_panel_entry;

  logic        clk;
  logic        rst;
  logic [15:0] key_hex;
  logic        key_load, key_storeinc, key_dec;
  logic        key_toA, key_toX, key_toY, key_toSP, key_toPC;
  logic        halted;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        reg_req;
  logic [2:0]  reg_sel;
  logic [15:0] reg_data;
  logic        reg_ack;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic [15:0] entry;
  logic [2:0]  ndigits;
  logic        busy;

  front_panel_entry dut (
    .clk(clk), .rst(rst), .key_hex(key_hex),
    .key_load(key_load), .key_storeinc(key_storeinc), .key_dec(key_dec),
    .key_toA(key_toA), .key_toX(key_toX), .key_toY(key_toY),
    .key_toSP(key_toSP), .key_toPC(key_toPC), .halted(halted),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_req(reg_req), .reg_sel(reg_sel), .reg_data(reg_data),
    .reg_ack(reg_ack), .disp_addr(disp_addr), .disp_data(disp_data),
    .entry(entry), .ndigits(ndigits), .busy(busy)
  );

  // kind: 0 = memory read, 1 = memory write, 2 = register write
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [2:0]  sel;
    logic [15:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   total;
  int   bad;

  // Model of the panel as seen by an operator.
  logic [15:0] m_entry;
  int          m_nd;
  logic [15:0] m_addr;
  logic [7:0]  m_data;

  // Responder controls.
  logic hold_ack;
  logic inject_ack;
  txn_t cur;
  bit   fresh;
  int   wt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents presented by the responder for any read address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic void push_mem(input int kind, input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.kind = kind; t.addr = a; t.wdata = d; t.sel = 3'd0; t.data = 16'h0;
    exp_q.push_back(t);
  endfunction

  // Applies one key cycle to the model; returns 1 if a transaction starts.
  function automatic bit model_apply(input logic [15:0] hex, input logic [7:0] cmd, input logic h);
    txn_t t;
    int   n;
    if (cmd != 8'h00) begin
      if (!h) return 1'b0;
      if (cmd[0]) begin
        m_addr = m_entry;
        push_mem(0, m_addr, 8'h00);
        m_data = mem_byte(m_addr);
        m_entry = 16'h0; m_nd = 0;
      end else if (cmd[1]) begin
        push_mem(1, m_addr, m_entry[7:0]);
        m_addr = m_addr + 16'd1;
        push_mem(0, m_addr, 8'h00);
        m_data = mem_byte(m_addr);
        m_entry = 16'h0; m_nd = 0;
      end else if (cmd[2]) begin
        m_addr = m_addr - 16'd1;
        push_mem(0, m_addr, 8'h00);
        m_data = mem_byte(m_addr);
      end else begin
        t.kind = 2; t.addr = 16'h0; t.wdata = 8'h00;
        if (cmd[3])      t.sel = 3'd4;
        else if (cmd[4]) t.sel = 3'd0;
        else if (cmd[5]) t.sel = 3'd1;
        else if (cmd[6]) t.sel = 3'd2;
        else             t.sel = 3'd3;
        t.data = (t.sel == 3'd4) ? m_entry : {8'h00, m_entry[7:0]};
        exp_q.push_back(t);
        m_entry = 16'h0; m_nd = 0;
      end
      return 1'b1;
    end
    if (hex != 16'h0) begin
      n = 0;
      for (int i = 15; i >= 0; i--) if (hex[i]) n = i;
      m_entry = (m_entry << 4) | 16'(n);
      m_nd = (m_nd < 4) ? m_nd + 1 : 4;
    end
    return 1'b0;
  endfunction

  task automatic set_keys(input logic [15:0] hex, input logic [7:0] cmd);
    key_hex = hex;
    {key_toSP, key_toY, key_toX, key_toA, key_toPC, key_dec, key_storeinc, key_load} = cmd;
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_reg_req", 32'(reg_req), 0);
    chk("rst_reg_sel", 32'(reg_sel), 0);
    chk("rst_reg_data", 32'(reg_data), 0);
    chk("rst_disp_addr", 32'(disp_addr), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_ndigits", 32'(ndigits), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Waits for the panel to go idle, throwing stray keys at it meanwhile.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      if ($urandom_range(0, 2) == 0) begin
        set_keys(16'($urandom), 8'($urandom));
        halted = 1'($urandom);
      end
      @(negedge clk); #1;
      set_keys(16'h0, 8'h00);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic step(input logic [15:0] hex, input logic [7:0] cmd, input logic h);
    bit acc;
    acc = model_apply(hex, cmd, h);
    @(negedge clk); #1;
    set_keys(hex, cmd);
    halted = h;
    @(negedge clk); #1;
    set_keys(16'h0, 8'h00);
    chk("busy_after_key", 32'(busy), 32'(acc));
    wait_idle();
    chk("entry", 32'(entry), 32'(m_entry));
    chk("ndigits", 32'(ndigits), 32'(m_nd));
    chk("disp_addr", 32'(disp_addr), 32'(m_addr));
    chk("disp_data", 32'(disp_data), 32'(m_data));
  endtask

  task automatic type_hex(input logic [15:0] val);
    for (int i = 3; i >= 0; i--) step(16'(1) << val[i*4 +: 4], 8'h00, 1'b1);
  endtask

  // Responder / monitor: pops the expected transaction when a request appears,
  // checks it each cycle it is held, then acknowledges after a random delay.
  initial begin
    fresh = 1'b1;
    wt = 0;
    mem_ack = 1'b0;
    reg_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      reg_ack = 1'b0;
      if (rst) begin
        fresh = 1'b1;
      end else if (inject_ack) begin
        mem_ack = 1'b1;
        reg_ack = 1'b1;
        mem_rdata = 8'hEE;
      end else if (mem_req || reg_req) begin
        if (fresh && exp_q.size() == 0) begin
          chk("unexpected_req", {30'h0, mem_req, reg_req}, 0);
          if (mem_req) begin mem_ack = 1'b1; mem_rdata = 8'h00; end
          else reg_ack = 1'b1;
        end else begin
          if (fresh) begin
            cur = exp_q.pop_front();
            fresh = 1'b0;
            wt = $urandom_range(0, 3);
          end
          chk("req_kind", {29'h0, mem_req, reg_req, mem_we},
              (cur.kind == 2) ? 32'b010 : ((cur.kind == 1) ? 32'b101 : 32'b100));
          if (cur.kind != 2) begin
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            if (cur.kind == 1) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
          end else begin
            chk("reg_sel", 32'(reg_sel), 32'(cur.sel));
            chk("reg_data", 32'(reg_data), 32'(cur.data));
          end
          if (!hold_ack) begin
            if (wt == 0) begin
              if (cur.kind == 2) reg_ack = 1'b1;
              else begin
                mem_ack = 1'b1;
                mem_rdata = (cur.kind == 0) ? mem_byte(cur.addr) : 8'($urandom);
              end
              fresh = 1'b1;
            end else begin
              wt--;
            end
          end
        end
      end else if (!fresh) begin
        chk("req_held", 0, 1);
        fresh = 1'b1;
      end
    end
  end

  initial begin
    logic [15:0] hx;
    logic [7:0]  cm;
    int          r;
    bit          acc;
    total = 0;
    bad = 0;
    hold_ack = 1'b0;
    inject_ack = 1'b0;
    m_entry = 16'h0; m_nd = 0; m_addr = 16'h0; m_data = 8'h00;
    rst = 1'b1;
    halted = 1'b0;
    set_keys(16'h0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    // Digits 1..5 with the CPU running: last four kept, count saturates.
    for (int d = 1; d <= 5; d++) step(16'(1) << d, 8'h00, 1'b0);
    chk("entry_2345", 32'(entry), 32'h2345);
    chk("ndigits_sat", 32'(ndigits), 4);
    step(16'h0, 8'h01, 1'b1);
    chk("load_addr", 32'(disp_addr), 32'h2345);

    // Store at FFFF wraps the panel address to 0000.
    type_hex(16'hFFFF);
    step(16'h0, 8'h01, 1'b1);
    step(16'h0008, 8'h00, 1'b1);
    step(16'h1000, 8'h00, 1'b1);
    chk("entry_3c", 32'(entry), 32'h003C);
    step(16'h0, 8'h02, 1'b1);
    chk("storeinc_wrap", 32'(disp_addr), 32'h0000);
    step(16'h0, 8'h04, 1'b1);
    chk("dec_wrap", 32'(disp_addr), 32'hFFFF);

    // Register transfers.
    type_hex(16'h1234);
    step(16'h0, 8'h08, 1'b1);
    type_hex(16'h1234);
    step(16'h0, 8'h10, 1'b1);
    chk("reg_clears_entry", 32'(entry), 0);

    // Simultaneous keys and ignored commands.
    type_hex(16'h0056);
    step(16'h0080, 8'h05, 1'b1);
    chk("load_beats_dec", 32'(disp_addr), 32'h0056);
    step(16'h0208, 8'h00, 1'b1);
    chk("lowest_digit", 32'(entry), 32'h0003);
    step(16'h0010, 8'h04, 1'b0);
    chk("cmd_drops_hex", 32'(entry), 32'h0003);
    step(16'h0, 8'hFF, 1'b0);

    // Reset in the middle of a read; a late ack must change nothing.
    type_hex(16'h4321);
    hold_ack = 1'b1;
    acc = model_apply(16'h0, 8'h01, 1'b1);
    @(negedge clk); #1;
    set_keys(16'h0, 8'h01);
    halted = 1'b1;
    @(negedge clk); #1;
    set_keys(16'h0, 8'h00);
    chk("busy_before_rst", 32'(busy), 32'(acc));
    chk("req_before_rst", 32'(mem_req), 1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_vals();
    m_entry = 16'h0; m_nd = 0; m_addr = 16'h0; m_data = 8'h00;
    exp_q.delete();
    rst = 1'b0;
    hold_ack = 1'b0;
    inject_ack = 1'b1;
    @(negedge clk); #1;
    inject_ack = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals();

    // Randomized key traffic.
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        hx = 16'(1) << $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) hx = hx | (16'(1) << $urandom_range(0, 15));
        cm = 8'h00;
      end else if (r < 8) begin
        hx = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
        cm = 8'(1) << $urandom_range(0, 7);
      end else begin
        hx = 16'($urandom);
        cm = 8'($urandom);
      end
      step(hx, cm, ($urandom_range(0, 4) != 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
